// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: a single-entry writeback register with load formatting,
// forwarding to decode, a misaligned-load pulse and a retired-instruction counter.
module mem_wb_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [4:0]  mem_rd_addr,
    input  logic        mem_rd_we,
    input  logic        mem_is_load,
    input  logic [31:0] mem_alu_result,
    input  logic [31:0] mem_load_data,
    input  logic [2:0]  mem_funct3,
    input  logic [1:0]  mem_addr_lo,
    input  logic        stall,
    input  logic        flush,
    output logic [4:0]  rd_addr,
    output logic [31:0] rd_data,
    output logic        rd_we,
    output logic        fwd_valid,
    output logic [4:0]  fwd_rd_addr,
    output logic [31:0] fwd_rd_data,
    output logic        load_misaligned,
    output logic [63:0] instret
);

    logic        wb_valid_q, wb_valid_d;
    logic [4:0]  wb_addr_q, wb_addr_d;
    logic        wb_we_q, wb_we_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        wb_mis_q, wb_mis_d;
    logic [63:0] instret_q, instret_d;

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_fmt;
    logic        ld_type_ok;
    logic        ld_mis;
    logic        retire;
    logic        wb_commit;

    // Load formatting: pick the addressed byte/half and extend by funct3.
    always_comb begin
        ld_byte    = 8'h0;
        ld_half    = mem_addr_lo[1] ? mem_load_data[31:16] : mem_load_data[15:0];
        ld_fmt     = 32'h0;
        ld_type_ok = 1'b1;
        ld_mis     = 1'b0;
        case (mem_addr_lo)
            2'd0:    ld_byte = mem_load_data[7:0];
            2'd1:    ld_byte = mem_load_data[15:8];
            2'd2:    ld_byte = mem_load_data[23:16];
            default: ld_byte = mem_load_data[31:24];
        endcase
        case (mem_funct3)
            3'b000: ld_fmt = {{24{ld_byte[7]}}, ld_byte};
            3'b100: ld_fmt = {24'h0, ld_byte};
            3'b001: begin
                ld_fmt = {{16{ld_half[15]}}, ld_half};
                ld_mis = mem_addr_lo[0];
            end
            3'b101: begin
                ld_fmt = {16'h0, ld_half};
                ld_mis = mem_addr_lo[0];
            end
            3'b010: begin
                ld_fmt = mem_load_data;
                ld_mis = (mem_addr_lo != 2'd0);
            end
            default: ld_type_ok = 1'b0;
        endcase
    end

    assign mem_ready = !stall;
    assign retire    = wb_valid_q && !stall && !flush;
    // An entry that may write the register file (also gates forwarding).
    assign wb_commit = wb_we_q && !wb_mis_q && (wb_addr_q != 5'd0);

    // Next-state for the writeback entry: flush beats stall, stall beats capture.
    always_comb begin
        wb_valid_d = wb_valid_q;
        wb_addr_d  = wb_addr_q;
        wb_we_d    = wb_we_q;
        wb_data_d  = wb_data_q;
        wb_mis_d   = wb_mis_q;
        instret_d  = retire ? instret_q + 64'd1 : instret_q;
        if (flush) begin
            wb_valid_d = 1'b0;
        end else if (!stall) begin
            if (mem_valid) begin
                wb_valid_d = 1'b1;
                wb_addr_d  = mem_rd_addr;
                if (mem_is_load) begin
                    wb_data_d = ld_fmt;
                    wb_we_d   = mem_rd_we && ld_type_ok;
                    wb_mis_d  = ld_mis;
                end else begin
                    wb_data_d = mem_alu_result;
                    wb_we_d   = mem_rd_we;
                    wb_mis_d  = 1'b0;
                end
            end else begin
                wb_valid_d = 1'b0;
            end
        end
    end

    // Entry and retire-counter state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid_q <= 1'b0;
            wb_addr_q  <= 5'd0;
            wb_we_q    <= 1'b0;
            wb_data_q  <= 32'h0;
            wb_mis_q   <= 1'b0;
            instret_q  <= 64'd0;
        end else begin
            wb_valid_q <= wb_valid_d;
            wb_addr_q  <= wb_addr_d;
            wb_we_q    <= wb_we_d;
            wb_data_q  <= wb_data_d;
            wb_mis_q   <= wb_mis_d;
            instret_q  <= instret_d;
        end
    end

    assign rd_we           = retire && wb_commit;
    assign rd_addr         = wb_addr_q;
    assign rd_data         = wb_data_q;
    assign fwd_valid       = wb_valid_q && wb_commit;
    assign fwd_rd_addr     = wb_addr_q;
    assign fwd_rd_data     = wb_data_q;
    assign load_misaligned = retire && wb_mis_q;
    assign instret         = instret_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed scenarios plus randomized
// traffic checked against a behavioural model of the writeback entry.
module tb_mem_wb_stage;

    logic        clk;
    logic        rst_n;
    logic        mem_valid;
    logic        mem_ready;
    logic [4:0]  mem_rd_addr;
    logic        mem_rd_we;
    logic        mem_is_load;
    logic [31:0] mem_alu_result;
    logic [31:0] mem_load_data;
    logic [2:0]  mem_funct3;
    logic [1:0]  mem_addr_lo;
    logic        stall;
    logic        flush;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        rd_we;
    logic        fwd_valid;
    logic [4:0]  fwd_rd_addr;
    logic [31:0] fwd_rd_data;
    logic        load_misaligned;
    logic [63:0] instret;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    bit          m_valid;
    bit [4:0]    m_addr;
    bit          m_we;
    bit [31:0]   m_data;
    bit          m_mis;
    bit [63:0]   m_instret;

    mem_wb_stage dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .mem_valid       (mem_valid),
        .mem_ready       (mem_ready),
        .mem_rd_addr     (mem_rd_addr),
        .mem_rd_we       (mem_rd_we),
        .mem_is_load     (mem_is_load),
        .mem_alu_result  (mem_alu_result),
        .mem_load_data   (mem_load_data),
        .mem_funct3      (mem_funct3),
        .mem_addr_lo     (mem_addr_lo),
        .stall           (stall),
        .flush           (flush),
        .rd_addr         (rd_addr),
        .rd_data         (rd_data),
        .rd_we           (rd_we),
        .fwd_valid       (fwd_valid),
        .fwd_rd_addr     (fwd_rd_addr),
        .fwd_rd_data     (fwd_rd_data),
        .load_misaligned (load_misaligned),
        .instret         (instret)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Load result per the RISC-V rules, built from arithmetic on the raw word.
    task automatic model_load(input bit [2:0] f3, input bit [1:0] lo, input bit [31:0] d,
                              output bit [31:0] val, output bit ok, output bit mis);
        bit [31:0] b;
        bit [31:0] h;
        b   = (d >> (8 * lo)) % 256;
        h   = (d >> (16 * (lo / 2))) % 65536;
        ok  = 1'b1;
        mis = 1'b0;
        val = 32'h0;
        case (f3)
            3'd0: val = (b >= 128) ? b + 32'hFFFF_FF00 : b;
            3'd4: val = b;
            3'd1: begin val = (h >= 32768) ? h + 32'hFFFF_0000 : h; mis = (lo % 2) != 0; end
            3'd5: begin val = h; mis = (lo % 2) != 0; end
            3'd2: begin val = d; mis = (lo != 0); end
            default: ok = 1'b0;
        endcase
    endtask

    function automatic bit m_retire();
        return m_valid && !stall && !flush;
    endfunction

    function automatic bit m_writes();
        return m_we && !m_mis && (m_addr != 0);
    endfunction

    task automatic model_reset();
        m_valid = 0; m_addr = 0; m_we = 0; m_data = 0; m_mis = 0; m_instret = 0;
    endtask

    // Advance the model by one rising edge using the inputs currently driven.
    task automatic model_step();
        bit [31:0] v;
        bit ok, mis;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (m_retire()) m_instret = m_instret + 1;
        if (flush) m_valid = 0;
        else if (!stall) begin
            if (mem_valid) begin
                m_valid = 1;
                m_addr  = mem_rd_addr;
                if (mem_is_load) begin
                    model_load(mem_funct3, mem_addr_lo, mem_load_data, v, ok, mis);
                    m_data = v;
                    m_we   = mem_rd_we && ok;
                    m_mis  = mis;
                end else begin
                    m_data = mem_alu_result;
                    m_we   = mem_rd_we;
                    m_mis  = 0;
                end
            end else m_valid = 0;
        end
    endtask

    task automatic check_outputs();
        check("mem_ready", mem_ready, !stall);
        check("rd_we", rd_we, m_retire() && m_writes());
        check("rd_addr", rd_addr, m_addr);
        check("rd_data", rd_data, m_data);
        check("fwd_valid", fwd_valid, m_valid && m_writes());
        check("fwd_rd_addr", fwd_rd_addr, m_addr);
        check("fwd_rd_data", fwd_rd_data, m_data);
        check("load_misaligned", load_misaligned, m_retire() && m_mis);
        check("instret", instret, m_instret);
    endtask

    // Called with inputs set just after a falling edge; ends on the next falling edge.
    task automatic tick();
        #1 check_outputs();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic drive(input bit v, input bit [4:0] rd, input bit we, input bit ld,
                         input bit [31:0] alu, input bit [31:0] d, input bit [2:0] f3,
                         input bit [1:0] lo);
        mem_valid = v; mem_rd_addr = rd; mem_rd_we = we; mem_is_load = ld;
        mem_alu_result = alu; mem_load_data = d; mem_funct3 = f3; mem_addr_lo = lo;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst_n = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        idle();
        model_reset();
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1 check_outputs();
        rst_n = 1'b1;

        // ALU op to x5
        drive(1, 5, 1, 0, 32'h1234, 0, 0, 0);
        tick();
        idle();
        #1;
        check("alu_rd_we", rd_we, 1);
        check("alu_rd_addr", rd_addr, 5);
        check("alu_rd_data", rd_data, 32'h1234);
        check("alu_instret0", instret, 0);
        tick();
        check("alu_instret1", instret, 1);

        // LB / LBU / LHU back to back
        drive(1, 7, 1, 1, 0, 32'h80FF_0000, 3'b000, 2'd3);
        tick();
        drive(1, 7, 1, 1, 0, 32'h80FF_0000, 3'b100, 2'd3);
        #1 check("lb_data", rd_data, 32'hFFFF_FF80);
        tick();
        drive(1, 7, 1, 1, 0, 32'h80FF_0000, 3'b101, 2'd2);
        #1 check("lbu_data", rd_data, 32'h0000_0080);
        tick();
        idle();
        #1 check("lhu_data", rd_data, 32'h0000_80FF);
        tick();

        // Misaligned LW
        drive(1, 8, 1, 1, 0, 32'hDEAD_BEEF, 3'b010, 2'd2);
        tick();
        idle();
        #1;
        check("lw_mis_rd_we", rd_we, 0);
        check("lw_mis_pulse", load_misaligned, 1);
        check("lw_mis_fwd", fwd_valid, 0);
        tick();
        check("lw_mis_pulse_off", load_misaligned, 0);
        check("lw_mis_instret", instret, 5);

        // Stall for three cycles, then release
        drive(1, 9, 1, 0, 32'hAA, 0, 0, 0);
        tick();
        idle();
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_rd_we", rd_we, 0);
            check("stall_fwd", fwd_valid, 1);
            tick();
        end
        stall = 0;
        #1 check("release_rd_we", rd_we, 1);
        tick();
        check("release_once", rd_we, 0);
        check("release_instret", instret, 6);

        // Flush a stalled entry, then write to x0
        drive(1, 10, 1, 0, 32'h55, 0, 0, 0);
        tick();
        idle();
        stall = 1;
        tick();
        flush = 1;
        tick();
        flush = 0;
        stall = 0;
        #1;
        check("flush_fwd", fwd_valid, 0);
        check("flush_rd_we", rd_we, 0);
        check("flush_instret", instret, 6);
        drive(1, 0, 1, 0, 32'h77, 0, 0, 0);
        tick();
        idle();
        #1 check("x0_rd_we", rd_we, 0);
        tick();
        check("x0_instret", instret, 7);

        // Asynchronous reset with a live entry
        drive(1, 3, 1, 0, 32'hCAFE, 0, 0, 0);
        tick();
        idle();
        #1 rst_n = 1'b0;
        #1;
        check("arst_rd_we", rd_we, 0);
        check("arst_fwd", fwd_valid, 0);
        check("arst_rd_data", rd_data, 0);
        check("arst_instret", instret, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 4, 1, 0, 32'h99, 0, 0, 0);
        tick();
        idle();
        #1 check("post_rst_capture", rd_we, 1);
        tick();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 9) < 7, 5'($urandom_range(0, 31)), 1'($urandom),
                  1'($urandom), $urandom, $urandom, 3'($urandom_range(0, 7)),
                  2'($urandom_range(0, 3)));
            if ($urandom_range(0, 7) == 0) mem_rd_addr = 0;
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 9) == 0);
            tick();
        end
        stall = 0;
        flush = 0;
        idle();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 SHALL have ports: clk  in  1  clock, rising edge; rst_n  in  1  reset, asynchronous, active-low.
REQ-002 SHALL have ports: mem_valid  in  1  MEM stage holds an instruction; mem_ready  out  1  WB can accept this cycle.
REQ-003 SHALL have ports: mem_rd_addr  in  5  destination register; mem_rd_we  in  1  instruction writes rd; mem_is_load  in  1  result comes from load data.
REQ-004 SHALL have ports: mem_alu_result  in  32  ALU/PC+4 result; mem_load_data  in  32  raw aligned-word read data; mem_funct3  in  3  load type; mem_addr_lo  in  2  byte offset of load address.
REQ-005 SHALL have ports: stall  in  1  hold WB entry; flush  in  1  kill WB entry.
REQ-006 SHALL have ports: rd_addr  out  5, rd_data  out  32, rd_we  out  1  register-file write port.
REQ-007 SHALL have ports: fwd_valid  out  1, fwd_rd_addr  out  5, fwd_rd_data  out  32  forwarding to decode.
REQ-008 SHALL have ports: load_misaligned  out  1  misaligned-load pulse; instret  out  64  retired-instruction count.

Function
REQ-009 SHALL hold a single-entry register: wb_valid, wb_addr[4:0], wb_we, wb_data[31:0], wb_mis.
REQ-010 SHALL drive mem_ready = !stall, combinationally.
REQ-011 SHALL capture the MEM inputs on a rising edge when mem_valid && mem_ready && !flush, setting wb_valid=1.
REQ-012 SHALL clear wb_valid on a rising edge when flush=1; flush overrides capture and stall.
REQ-013 SHALL hold all entry fields unchanged when stall=1 and flush=0.
REQ-014 SHALL clear wb_valid when stall=0, flush=0 and mem_valid=0 (bubble).
REQ-015 SHALL compute wb_data at capture, so the write appears one cycle after acceptance: mem_alu_result if mem_is_load=0, else the formatted load.
REQ-016 SHALL format loads by funct3: 000 LB = sign-extended byte at addr_lo; 100 LBU = zero-extended byte; 001 LH = sign-extended half at addr_lo[1]; 101 LHU = zero-extended half; 010 LW = full word; other codes = 32'h0 with wb_we forced to 0.
REQ-017 SHALL set wb_mis=1 for LH/LHU with addr_lo[0]=1, or LW with addr_lo!=0; wb_mis=0 for non-loads.
REQ-018 SHALL define retire as wb_valid && !stall && !flush.
REQ-019 SHALL drive rd_we = retire && wb_we && !wb_mis && (wb_addr != 0); rd_addr = wb_addr and rd_data = wb_data at all times.
REQ-020 SHALL drive fwd_valid = wb_valid && wb_we && !wb_mis && (wb_addr != 0), independent of stall; fwd_rd_addr = wb_addr; fwd_rd_data = wb_data.
REQ-021 SHALL assert load_misaligned = retire && wb_mis for exactly the retiring cycle, combinationally.
REQ-022 SHALL increment instret by 1 on each rising edge where retire=1, including misaligned and x0-destination instructions, wrapping 2^64-1 -> 0.
REQ-023 SHALL never retire the same entry twice: an entry retires exactly once, or is killed by flush without retiring.

Reset
REQ-024 SHALL, on rst_n=0 and asynchronously: wb_valid=0, wb_addr=0, wb_we=0, wb_data=0, wb_mis=0, instret=0; hence rd_we=0, fwd_valid=0, load_misaligned=0.
REQ-025 SHALL discard any in-flight entry on reset mid-operation; the first capture is allowed on the first rising edge after rst_n deasserts.

Verification
REQ-026 ALU op: mem_valid=1, rd=5, alu=32'h1234, is_load=0 -> next cycle rd_we=1, rd_addr=5, rd_data=32'h1234; instret 0->1.
REQ-027 LB at addr_lo=3, load_data=32'h80FF_0000 -> rd_data=32'hFFFF_FF80; LBU same -> 32'h0000_0080; LHU at addr_lo=2 -> 32'h0000_80FF.
REQ-028 LW at addr_lo=2 -> rd_we=0, load_misaligned=1 for one cycle, fwd_valid=0, instret increments.
REQ-029 Capture, then stall=1 for 3 cycles -> rd_we=0, fwd_valid=1 throughout; on stall release rd_we=1 once, instret +1 only.
REQ-030 Flush while an entry is stalled -> entry killed, no rd_we, instret unchanged; write to rd=0 -> rd_we=0, instret +1.
REQ-031 rst_n low while wb_valid=1 -> all outputs 0 immediately, without waiting for a clock edge.
